cl_sim_mem_axil_init: RTL and testbench
=======================================

// Module: cl_sim_mem_axil_init
// PURPOSE
//  AXI4-Lite 64b initiator: drives the simulation-memory AXI-Lite responder from a simple cmd/rsp stream.
//  Used by bench backdoor loaders and checkers to preload and read back sim memory without the 512b DMA path.
//  One outstanding transaction; write and read share one command port; every command yields exactly one response.
// PARAMETERS
//  ADDR_W          64    AXI-Lite address width
//  DATA_W          64    AXI-Lite data width; STRB_W = DATA_W/8
//  TIMEOUT_CYCLES  1024  B/R wait limit, used only when CL_SIM_MEM_INIT_TIMEOUT_EN is defined
// PORTS
//  aclk        in   1       clock; all logic on rising edge
//  aresetn     in   1       asynchronous active-low reset
//  cmd_valid   in   1       command present
//  cmd_ready   out  1       command accepted when cmd_valid & cmd_ready
//  cmd_wr      in   1       1=write, 0=read
//  cmd_addr    in   ADDR_W  byte address, passed to awaddr/araddr unmodified
//  cmd_wdata   in   DATA_W  write data (ignored on read)
//  cmd_wstrb   in   STRB_W  write byte strobes (ignored on read)
//  rsp_valid   out  1       response present
//  rsp_ready   in   1       response consumed when rsp_valid & rsp_ready
//  rsp_wr      out  1       response belongs to a write
//  rsp_rdata   out  DATA_W  read data (0 for writes)
//  rsp_resp    out  2       bresp/rresp, or 2'b11 on timeout
//  rsp_timeout out  1       1 = transaction abandoned by watchdog (0 when macro undefined)
//  mem_axi_aw{valid,addr,ready}, w{valid,data,strb,ready}, b{valid,resp,ready},
//  ar{valid,addr,ready}, r{valid,data,resp,ready}: AXI-Lite master, standard directions/widths
// BEHAVIOUR
//  Reset (async assert): state=IDLE; cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready = 0;
//   rsp_* data regs = 0. First cycle after deassert: cmd_ready=1. All outputs registered.
//  FSM: IDLE -> WR (cmd_wr=1) | RD_A (cmd_wr=0) on accept; cmd_ready drops same edge.
//  WR: awvalid & wvalid rise the cycle after accept; each drops independently on its own handshake;
//   bready=1 once both done -> WR_B. AW and W may complete in either order or the same cycle.
//  WR_B: on bvalid&bready capture bresp, bready=0 -> RSP. RD_A: arvalid held until arready -> RD_R
//   with rready=1; on rvalid&rready capture rdata/rresp -> RSP.
//  RSP: rsp_valid=1, payload stable until rsp_ready; then -> IDLE, cmd_ready=1 next cycle.
//  Min latency (zero-wait responder): accept@0, AW/W@1, B@2, rsp_valid@3, cmd_ready@4 after rsp_ready.
//  VALID never deasserted before its READY; addr/data held stable while VALID high.
//  Unexpected bvalid/rvalid outside WR_B/RD_R: ignored (ready low); protocol assertion flags it in sim.
//  Reset mid-transaction: transaction dropped, no response; responder must be reset alongside.
// CONFIGURATION
//  CL_SIM_MEM_INIT_TIMEOUT_EN defined: counter starts on entering WR/RD_A, clears on state change;
//   reaching TIMEOUT_CYCLES drops all AXI valids/readies, enters RSP with rsp_resp=2'b11, rsp_timeout=1,
//   then stays in RSP's successor IDLE; late B/R beats ignored. Undefined: no counter, waits forever, rsp_timeout=0.
// STRUCTURE
//  cl_sim_mem_pkg: state enum (IDLE, WR, WR_B, RD_A, RD_R, RSP), AXI resp localparams (OKAY/SLVERR/DECERR).
//  Single flat module; no sub-module (timeout counter is a few lines under the macro).
// TESTING
//  1 write 0x1000 data 0xDEADBEEF_CAFEF00D strb 0xFF, read 0x1000 -> rsp_rdata=0xDEADBEEF_CAFEF00D, rsp_resp=0.
//  2 awready delayed 3 cycles, wready immediate -> wvalid drops after 1 beat, awvalid held 4 cycles, one B, one rsp.
//  3 write 0x2000 strb 0x0F data 0x11111111_22222222 over 0xFFFFFFFF_FFFFFFFF -> read 0xFFFFFFFF_22222222.
//  4 responder rresp=2'b10; rsp_ready low 5 cycles -> rsp_resp=2'b10 held stable, cmd_ready=0, no new AR.
//  5 macro on, bvalid never -> after 1024 cycles rsp_resp=2'b11, rsp_timeout=1; macro off -> still in WR_B.
//  6 aresetn low while arvalid=1 -> arvalid=0 immediately, no rsp; after release cmd_ready=1, next read completes.

Source files
------------

// File: rtl/cl_sim_mem_pkg.sv
// Shared types for the simulation-memory AXI4-Lite initiator: FSM states and AXI response codes.
package cl_sim_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_B,
        RD_A,
        RD_R,
        RSP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/cl_sim_mem_axil_init.sv
// AXI4-Lite initiator turning a single-outstanding cmd/rsp stream into AW/W/B or AR/R transactions.
// Optional B/R watchdog enabled by defining CL_SIM_MEM_INIT_TIMEOUT_EN.
module cl_sim_mem_axil_init
    import cl_sim_mem_pkg::*;
#(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                aclk,
    input  logic                aresetn,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_wr,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_wr,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,

    output logic                mem_axi_awvalid,
    output logic [ADDR_W-1:0]   mem_axi_awaddr,
    input  logic                mem_axi_awready,
    output logic                mem_axi_wvalid,
    output logic [DATA_W-1:0]   mem_axi_wdata,
    output logic [DATA_W/8-1:0] mem_axi_wstrb,
    input  logic                mem_axi_wready,
    input  logic                mem_axi_bvalid,
    input  logic [1:0]          mem_axi_bresp,
    output logic                mem_axi_bready,
    output logic                mem_axi_arvalid,
    output logic [ADDR_W-1:0]   mem_axi_araddr,
    input  logic                mem_axi_arready,
    input  logic                mem_axi_rvalid,
    input  logic [DATA_W-1:0]   mem_axi_rdata,
    input  logic [1:0]          mem_axi_rresp,
    output logic                mem_axi_rready
);

    state_t state;
    logic   tmo_hit;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

`ifdef CL_SIM_MEM_INIT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t             state_d;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               waiting;

    assign waiting = state inside {WR, WR_B, RD_A, RD_R};
    // state != state_d marks the first cycle in a state, when tmo_cnt is still stale.
    assign tmo_hit = waiting && (state == state_d) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_d <= IDLE;
            tmo_cnt <= '0;
        end else begin
            state_d <= state;
            if (!waiting)
                tmo_cnt <= '0;
            else if (state != state_d)
                tmo_cnt <= TMO_W'(1);
            else
                tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // NOTE: every register here is updated with <= so all of them see pre-edge values of each other.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state           <= IDLE;
            cmd_ready       <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_wr          <= 1'b0;
            rsp_rdata       <= '0;
            rsp_resp        <= RESP_OKAY;
            rsp_timeout     <= 1'b0;
            mem_axi_awvalid <= 1'b0;
            mem_axi_awaddr  <= '0;
            mem_axi_wvalid  <= 1'b0;
            mem_axi_wdata   <= '0;
            mem_axi_wstrb   <= '0;
            mem_axi_bready  <= 1'b0;
            mem_axi_arvalid <= 1'b0;
            mem_axi_araddr  <= '0;
            mem_axi_rready  <= 1'b0;
        end else if (tmo_hit) begin
            mem_axi_awvalid <= 1'b0;
            mem_axi_wvalid  <= 1'b0;
            mem_axi_bready  <= 1'b0;
            mem_axi_arvalid <= 1'b0;
            mem_axi_rready  <= 1'b0;
            rsp_rdata       <= '0;
            rsp_resp        <= RESP_DECERR;
            rsp_timeout     <= 1'b1;
            rsp_valid       <= 1'b1;
            state           <= RSP;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready   <= 1'b0;
                        rsp_wr      <= cmd_wr;
                        rsp_rdata   <= '0;
                        rsp_resp    <= RESP_OKAY;
                        rsp_timeout <= 1'b0;
                        if (cmd_wr) begin
                            mem_axi_awvalid <= 1'b1;
                            mem_axi_awaddr  <= cmd_addr;
                            mem_axi_wvalid  <= 1'b1;
                            mem_axi_wdata   <= cmd_wdata;
                            mem_axi_wstrb   <= cmd_wstrb;
                            state           <= WR;
                        end else begin
                            mem_axi_arvalid <= 1'b1;
                            mem_axi_araddr  <= cmd_addr;
                            state           <= RD_A;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WR: begin
                    if (mem_axi_awready)
                        mem_axi_awvalid <= 1'b0;
                    if (mem_axi_wready)
                        mem_axi_wvalid <= 1'b0;
                    // Each channel is done once its valid is already low or handshakes this edge.
                    if ((!mem_axi_awvalid || mem_axi_awready) && (!mem_axi_wvalid || mem_axi_wready)) begin
                        mem_axi_bready <= 1'b1;
                        state          <= WR_B;
                    end
                end
                WR_B: begin
                    if (mem_axi_bvalid) begin
                        mem_axi_bready <= 1'b0;
                        rsp_resp       <= mem_axi_bresp;
                        rsp_valid      <= 1'b1;
                        state          <= RSP;
                    end
                end
                RD_A: begin
                    if (mem_axi_arready) begin
                        mem_axi_arvalid <= 1'b0;
                        mem_axi_rready  <= 1'b1;
                        state           <= RD_R;
                    end
                end
                RD_R: begin
                    if (mem_axi_rvalid) begin
                        mem_axi_rready <= 1'b0;
                        rsp_rdata      <= mem_axi_rdata;
                        rsp_resp       <= mem_axi_rresp;
                        rsp_valid      <= 1'b1;
                        state          <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_no_stray_b: assert property (@(posedge aclk) disable iff (!aresetn)
        mem_axi_bvalid |-> state == WR_B);
    a_no_stray_r: assert property (@(posedge aclk) disable iff (!aresetn)
        mem_axi_rvalid |-> state == RD_R);

endmodule

// File: tb/tb_cl_sim_mem_axil_init.sv
// Self-checking bench for cl_sim_mem_axil_init: directed scenarios plus randomized traffic against a memory model.
module tb_cl_sim_mem_axil_init;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [63:0] cmd_addr, cmd_wdata;
    logic [7:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_wr, rsp_timeout;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        mem_axi_awvalid, mem_axi_awready, mem_axi_wvalid, mem_axi_wready;
    logic [63:0] mem_axi_awaddr, mem_axi_wdata, mem_axi_araddr, mem_axi_rdata;
    logic [7:0]  mem_axi_wstrb;
    logic        mem_axi_bvalid, mem_axi_bready, mem_axi_arvalid, mem_axi_arready;
    logic        mem_axi_rvalid, mem_axi_rready;
    logic [1:0]  mem_axi_bresp, mem_axi_rresp;

    int checks = 0;
    int errors = 0;

    bit [63:0] rmem [bit [63:0]];   // responder-side memory, written from observed AXI beats
    bit [63:0] mmem [bit [63:0]];   // reference model, written from issued commands

    typedef struct {
        bit        wr;
        bit [63:0] addr;
        bit [63:0] wdata;
        bit [7:0]  strb;
        int        aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
        bit [1:0]  resp;
        int        max_cyc;
    } txn_t;

    typedef struct {
        bit        done;
        bit        wr;
        bit [63:0] rdata;
        bit [1:0]  resp;
        bit        tmo;
        int        lat;
        int        rsp_cyc;
        int        aw_cnt, w_cnt;
        bit        addr_bad, data_bad, unstable, busy_bad;
    } res_t;

    cl_sim_mem_axil_init dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_wr          (cmd_wr),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .cmd_wstrb       (cmd_wstrb),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_wr          (rsp_wr),
        .rsp_rdata       (rsp_rdata),
        .rsp_resp        (rsp_resp),
        .rsp_timeout     (rsp_timeout),
        .mem_axi_awvalid (mem_axi_awvalid),
        .mem_axi_awaddr  (mem_axi_awaddr),
        .mem_axi_awready (mem_axi_awready),
        .mem_axi_wvalid  (mem_axi_wvalid),
        .mem_axi_wdata   (mem_axi_wdata),
        .mem_axi_wstrb   (mem_axi_wstrb),
        .mem_axi_wready  (mem_axi_wready),
        .mem_axi_bvalid  (mem_axi_bvalid),
        .mem_axi_bresp   (mem_axi_bresp),
        .mem_axi_bready  (mem_axi_bready),
        .mem_axi_arvalid (mem_axi_arvalid),
        .mem_axi_araddr  (mem_axi_araddr),
        .mem_axi_arready (mem_axi_arready),
        .mem_axi_rvalid  (mem_axi_rvalid),
        .mem_axi_rdata   (mem_axi_rdata),
        .mem_axi_rresp   (mem_axi_rresp),
        .mem_axi_rready  (mem_axi_rready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL global_watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit [63:0] merge(input bit [63:0] old, input bit [63:0] nw, input bit [7:0] strb);
        bit [63:0] v = old;
        for (int i = 0; i < 8; i++)
            if (strb[i]) v[i*8 +: 8] = nw[i*8 +: 8];
        return v;
    endfunction

    function automatic bit [63:0] rd_mem(input bit [63:0] a, input bit from_model);
        if (from_model) return mmem.exists(a) ? mmem[a] : 64'd0;
        return rmem.exists(a) ? rmem[a] : 64'd0;
    endfunction

    function automatic txn_t mk(input bit wr, input bit [63:0] addr, input bit [63:0] wdata, input bit [7:0] strb);
        txn_t t;
        t.wr = wr; t.addr = addr; t.wdata = wdata; t.strb = strb;
        t.aw_dly = 0; t.w_dly = 0; t.b_dly = 0; t.ar_dly = 0; t.r_dly = 0; t.rsp_dly = 0;
        t.resp = 2'b00;
        t.max_cyc = 64;
        return t;
    endfunction

    // Expected response from the reference model; also commits writes to the model.
    task automatic model_txn(input txn_t t, output bit [63:0] exp_rdata);
        if (t.wr) begin
            mmem[t.addr] = merge(rd_mem(t.addr, 1'b1), t.wdata, t.strb);
            exp_rdata = 64'd0;
        end else begin
            exp_rdata = rd_mem(t.addr, 1'b1);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_wr = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 0;
        mem_axi_awready = 0; mem_axi_wready = 0; mem_axi_bvalid = 0; mem_axi_bresp = 0;
        mem_axi_arready = 0; mem_axi_rvalid = 0; mem_axi_rdata = '0; mem_axi_rresp = 0;
    endtask

    // Issues one command and plays the AXI responder cycle by cycle; entered and left at a negedge.
    task automatic run_txn(input txn_t t, output res_t r);
        int c = 0, acc_c = 0;
        int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
        bit aw_done = 0, w_done = 0, b_done = 0, ar_done = 0, r_done = 0, written = 0;
        bit [63:0] aw_a = 0, w_d = 0, ar_a = 0;
        bit [7:0]  w_s = 0;
        bit cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire, rsp_fire;
        r = '{default: 0};
        r.lat = -1;
        cmd_valid = 1; cmd_wr = t.wr; cmd_addr = t.addr; cmd_wdata = t.wdata; cmd_wstrb = t.strb;
        while (!r.done && c < t.max_cyc) begin
            mem_axi_awready = mem_axi_awvalid && aw_wait >= t.aw_dly;
            mem_axi_wready  = mem_axi_wvalid && w_wait >= t.w_dly;
            mem_axi_bvalid  = aw_done && w_done && !b_done && b_wait >= t.b_dly;
            mem_axi_bresp   = mem_axi_bvalid ? t.resp : 2'b00;
            mem_axi_arready = mem_axi_arvalid && ar_wait >= t.ar_dly;
            mem_axi_rvalid  = ar_done && !r_done && r_wait >= t.r_dly;
            mem_axi_rdata   = mem_axi_rvalid ? rd_mem(ar_a, 1'b0) : 64'd0;
            mem_axi_rresp   = mem_axi_rvalid ? t.resp : 2'b00;
            rsp_ready       = rsp_valid && r.rsp_cyc >= t.rsp_dly;

            if (mem_axi_awvalid) begin
                r.aw_cnt++;
                if (mem_axi_awaddr !== t.addr) r.addr_bad = 1;
            end
            if (mem_axi_wvalid) begin
                r.w_cnt++;
                if (mem_axi_wdata !== t.wdata || mem_axi_wstrb !== t.strb) r.data_bad = 1;
            end
            if (mem_axi_arvalid && mem_axi_araddr !== t.addr) r.addr_bad = 1;
            if (rsp_valid) begin
                if (r.rsp_cyc == 0) begin
                    r.lat = c - acc_c;
                    r.wr = rsp_wr; r.rdata = rsp_rdata; r.resp = rsp_resp; r.tmo = rsp_timeout;
                end else if (rsp_wr !== r.wr || rsp_rdata !== r.rdata || rsp_resp !== r.resp
                             || rsp_timeout !== r.tmo) begin
                    r.unstable = 1;
                end
                if (cmd_ready || mem_axi_awvalid || mem_axi_wvalid || mem_axi_arvalid) r.busy_bad = 1;
                r.rsp_cyc++;
            end

            cmd_fire = cmd_valid && cmd_ready;
            aw_fire  = mem_axi_awvalid && mem_axi_awready;
            w_fire   = mem_axi_wvalid && mem_axi_wready;
            b_fire   = mem_axi_bvalid && mem_axi_bready;
            ar_fire  = mem_axi_arvalid && mem_axi_arready;
            r_fire   = mem_axi_rvalid && mem_axi_rready;
            rsp_fire = rsp_valid && rsp_ready;
            if (mem_axi_awvalid) aw_wait++;
            if (mem_axi_wvalid) w_wait++;
            if (aw_done && w_done && !b_done) b_wait++;
            if (mem_axi_arvalid) ar_wait++;
            if (ar_done && !r_done) r_wait++;
            if (aw_fire) aw_a = mem_axi_awaddr;
            if (w_fire) begin w_d = mem_axi_wdata; w_s = mem_axi_wstrb; end
            if (ar_fire) ar_a = mem_axi_araddr;

            @(posedge aclk);
            if (cmd_fire) acc_c = c;
            if (aw_fire) aw_done = 1;
            if (w_fire) w_done = 1;
            if (aw_done && w_done && !written) begin
                written = 1;
                rmem[aw_a] = merge(rd_mem(aw_a, 1'b0), w_d, w_s);
            end
            if (b_fire) b_done = 1;
            if (ar_fire) ar_done = 1;
            if (r_fire) r_done = 1;
            if (rsp_fire) r.done = 1;
            c++;
            @(negedge aclk);
            if (cmd_fire) cmd_valid = 0;
        end
        idle_inputs();
    endtask

    // Runs a transaction and compares everything the model predicts for a normal completion.
    task automatic run_and_check(input string tag, input txn_t t, output res_t r);
        bit [63:0] exp_rdata;
        model_txn(t, exp_rdata);
        run_txn(t, r);
        check({tag, "_done"}, 64'(r.done), 64'd1);
        check({tag, "_wr"}, 64'(r.wr), 64'(t.wr));
        check({tag, "_rdata"}, r.rdata, exp_rdata);
        check({tag, "_resp"}, 64'(r.resp), 64'(t.resp));
        check({tag, "_timeout"}, 64'(r.tmo), 64'd0);
        check({tag, "_axi_addr"}, 64'(r.addr_bad), 64'd0);
        check({tag, "_axi_wdata"}, 64'(r.data_bad), 64'd0);
        check({tag, "_rsp_stable"}, 64'(r.unstable), 64'd0);
        check({tag, "_busy_in_rsp"}, 64'(r.busy_bad), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 0;
        repeat (2) @(negedge aclk);
        aresetn = 1;
        @(negedge aclk);
    endtask

    initial begin
        txn_t t;
        res_t r;
        idle_inputs();
        aresetn = 0;
        repeat (3) @(negedge aclk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_awvalid", 64'(mem_axi_awvalid), 64'd0);
        check("rst_wvalid", 64'(mem_axi_wvalid), 64'd0);
        check("rst_bready", 64'(mem_axi_bready), 64'd0);
        check("rst_arvalid", 64'(mem_axi_arvalid), 64'd0);
        check("rst_rready", 64'(mem_axi_rready), 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_rsp_resp", 64'(rsp_resp), 64'd0);
        check("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        aresetn = 1;
        @(negedge aclk);
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // Basic write/readback with a zero-wait responder, including minimum latency.
        t = mk(1, 64'h1000, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        run_and_check("t1_wr", t, r);
        check("t1_wr_latency", 64'(r.lat), 64'd3);
        check("t1_cmd_ready_after", 64'(cmd_ready), 64'd1);
        t = mk(0, 64'h1000, 64'h0, 8'h0);
        run_and_check("t1_rd", t, r);
        check("t1_rd_latency", 64'(r.lat), 64'd3);
        check("t1_rd_value", r.rdata, 64'hDEADBEEF_CAFEF00D);

        // AW accepted three cycles late while W goes through at once.
        t = mk(1, 64'h3000, 64'h0123_4567_89AB_CDEF, 8'hFF);
        t.aw_dly = 3;
        run_and_check("t2", t, r);
        check("t2_awvalid_cycles", 64'(r.aw_cnt), 64'd4);
        check("t2_wvalid_cycles", 64'(r.w_cnt), 64'd1);

        // Partial strobe over an all-ones word.
        t = mk(1, 64'h2000, 64'hFFFFFFFF_FFFFFFFF, 8'hFF);
        run_and_check("t3_fill", t, r);
        t = mk(1, 64'h2000, 64'h11111111_22222222, 8'h0F);
        run_and_check("t3_part", t, r);
        t = mk(0, 64'h2000, 64'h0, 8'h0);
        run_and_check("t3_rd", t, r);
        check("t3_rd_value", r.rdata, 64'hFFFFFFFF_22222222);

        // Error response held while the consumer stalls.
        t = mk(0, 64'h1000, 64'h0, 8'h0);
        t.resp = 2'b10;
        t.rsp_dly = 5;
        run_and_check("t4", t, r);
        check("t4_rsp_cycles", 64'(r.rsp_cyc), 64'd6);

        // Responder never returns B.
        t = mk(1, 64'h5000, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF);
        t.b_dly = 100000;
`ifdef CL_SIM_MEM_INIT_TIMEOUT_EN
        t.max_cyc = 1200;
        run_txn(t, r);
        check("t5_done", 64'(r.done), 64'd1);
        check("t5_resp", 64'(r.resp), 64'd3);
        check("t5_timeout", 64'(r.tmo), 64'd1);
        check("t5_wr", 64'(r.wr), 64'd1);
        check("t5_latency", 64'(r.lat), 64'd1026);
        check("t5_bready_after", 64'(mem_axi_bready), 64'd0);
        check("t5_cmd_ready_after", 64'(cmd_ready), 64'd1);
`else
        t.max_cyc = 1100;
        run_txn(t, r);
        check("t5_done", 64'(r.done), 64'd0);
        check("t5_still_wr_b_bready", 64'(mem_axi_bready), 64'd1);
        check("t5_no_rsp", 64'(rsp_valid), 64'd0);
        check("t5_no_cmd_ready", 64'(cmd_ready), 64'd0);
`endif
        // The write reached the responder's memory; mirror it in the model.
        mmem[t.addr] = merge(rd_mem(t.addr, 1'b1), t.wdata, t.strb);
        do_reset();

        // Reset while a read address is outstanding.
        t = mk(0, 64'h2000, 64'h0, 8'h0);
        t.ar_dly = 1000;
        t.max_cyc = 4;
        run_txn(t, r);
        check("t6_pending_done", 64'(r.done), 64'd0);
        check("t6_arvalid_before", 64'(mem_axi_arvalid), 64'd1);
        #2 aresetn = 0;
        #1;
        check("t6_arvalid_in_rst", 64'(mem_axi_arvalid), 64'd0);
        check("t6_rready_in_rst", 64'(mem_axi_rready), 64'd0);
        check("t6_cmd_ready_in_rst", 64'(cmd_ready), 64'd0);
        repeat (2) @(negedge aclk);
        check("t6_no_rsp", 64'(rsp_valid), 64'd0);
        aresetn = 1;
        @(negedge aclk);
        check("t6_cmd_ready_after", 64'(cmd_ready), 64'd1);
        t = mk(0, 64'h2000, 64'h0, 8'h0);
        run_and_check("t6_rd", t, r);

        // Randomized mixed traffic over a small address window.
        for (int i = 0; i < 24; i++) begin
            t = mk($urandom_range(0, 1) == 1, 64'h4000 + 64'(8 * $urandom_range(0, 7)),
                   {$urandom, $urandom}, 8'($urandom_range(0, 255)));
            t.aw_dly  = $urandom_range(0, 3);
            t.w_dly   = $urandom_range(0, 3);
            t.b_dly   = $urandom_range(0, 3);
            t.ar_dly  = $urandom_range(0, 3);
            t.r_dly   = $urandom_range(0, 3);
            t.rsp_dly = $urandom_range(0, 2);
            t.resp    = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
            run_and_check($sformatf("rnd%0d", i), t, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
